// File: rtl/fp_add_normalize.sv
// FP32 adder back end: adds or subtracts the aligned mantissas, normalizes left one
// step per cycle, rounds to nearest-even and packs the IEEE-754 single result.
module fp_add_normalize #(
    parameter int NORM_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_of_great,
    input  logic        sign_of_small,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis_great,
    input  logic [27:0] mantis_small,
    input  logic [31:0] special_result,
    input  logic        special_case,
    input  logic        loss,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        inexact
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic        loss_q, loss_d;
    logic [8:0]  exp_q, exp_d;
    logic [27:0] mant_q, mant_d;
    logic [27:0] small_q, small_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        inx_q, inx_d;

    // add stage
    logic [27:0] add_raw, add_s;
    logic        add_zero;

    // normalize stage
    logic [2:0]  lz_cnt;
    logic        lz_hit;
    logic [8:0]  exp_room;
    logic [2:0]  sh_amt;
    logic [27:0] norm_m;
    logic [8:0]  norm_e;
    logic        norm_done;

    // round stage
    logic        rnd_g, rnd_rs, rnd_inc, rnd_hid, rnd_ovf;
    logic [24:0] rnd_m;
    logic [8:0]  rnd_e;
    logic [22:0] rnd_frac;

    always_comb begin
        add_raw  = sub_q ? (mant_q - small_q) : (mant_q + small_q);
        add_s    = add_raw | {27'd0, loss_q};
        add_zero = (add_raw == 28'd0) && !loss_q;
    end

    // Shift is bounded by the leading zeros in the NORM_SHIFT-wide window, and by
    // exp-1 so the exponent never drops below the denormal encoding of 1.
    always_comb begin
        lz_cnt = 3'd0;
        lz_hit = 1'b0;
        for (int i = 0; i < NORM_SHIFT; i++) begin
            if (!lz_hit && !mant_q[26-i]) lz_cnt = lz_cnt + 3'd1;
            else lz_hit = 1'b1;
        end
        exp_room = exp_q - 9'd1;
        if (mant_q[26] || (exp_q <= 9'd1))
            sh_amt = 3'd0;
        else if ({6'd0, lz_cnt} > exp_room)
            sh_amt = exp_room[2:0];
        else
            sh_amt = lz_cnt;
        norm_m    = mant_q << sh_amt;
        norm_e    = exp_q - {6'd0, sh_amt};
        norm_done = norm_m[26] || (norm_e <= 9'd1);
    end

    always_comb begin
        rnd_g    = mant_q[2];
        rnd_rs   = mant_q[1] | mant_q[0];
        rnd_inc  = rnd_g & (rnd_rs | mant_q[3]);
        rnd_m    = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
        rnd_e    = exp_q;
        rnd_hid  = rnd_m[23];
        rnd_frac = rnd_m[22:0];
        if (rnd_m[24]) begin
            rnd_e    = exp_q + 9'd1;
            rnd_hid  = 1'b1;
            rnd_frac = 23'd0;
        end
        rnd_ovf = (rnd_e >= 9'd255);
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        loss_d  = loss_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        small_d = small_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        inx_d   = inx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (special_case) begin
                        res_d   = special_result;
                        ovf_d   = 1'b0;
                        inx_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        sign_d  = sign_of_great;
                        sub_d   = sign_of_great ^ sign_of_small;
                        loss_d  = loss;
                        exp_d   = {1'b0, exp};
                        mant_d  = mantis_great;
                        small_d = mantis_small;
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                if (add_zero) begin
                    res_d   = 32'd0;
                    ovf_d   = 1'b0;
                    inx_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    // carry out: fold the dropped bit into sticky
                    if (add_s[27]) begin
                        mant_d = {1'b0, add_s[27:2], add_s[1] | add_s[0]};
                        exp_d  = exp_q + 9'd1;
                    end else begin
                        mant_d = add_s;
                    end
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                mant_d = norm_m;
                exp_d  = norm_e;
                if (norm_done) state_d = S_ROUND;
            end
            S_ROUND: begin
                if (rnd_ovf) begin
                    res_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    res_d = {sign_q, rnd_hid ? rnd_e[7:0] : 8'h00, rnd_frac};
                    ovf_d = 1'b0;
                    inx_d = rnd_g | rnd_rs;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            loss_q  <= 1'b0;
            exp_q   <= 9'd0;
            mant_q  <= 28'd0;
            small_q <= 28'd0;
            res_q   <= 32'd0;
            ovf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            loss_q  <= loss_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            small_q <= small_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            inx_q   <= inx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign inexact   = inx_q;

endmodule
